spi_adc_sequencer: RTL

- Memory-mapped hardware SPI master on the PicoRV32 native memory bus; replaces CPU bit-banging of the SAR ADC SPI pins.
- The CPU programs a command word and clock divider, then starts single or continuous conversion frames.
- The block sequences CS/SCK/MOSI, samples MISO, and latches each result with DONE/OVERRUN status.

---
 rtl/spi_adc_sequencer.sv | 296 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_adc_sequencer.sv
// SPI master for a SAR ADC on the PicoRV32 native memory bus.
// Sequences CS/SCK/MOSI in mode 0, samples MISO and latches each result with DONE/OVERRUN status.
module spi_adc_sequencer #(
    parameter logic [31:0] BASE_ADDR  = 32'h2000_0010,
    parameter int          FRAME_BITS = 16,
    parameter int          DIV_WIDTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        spi_cs,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS);

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_DATA   = 3'd2;
    localparam logic [2:0] REG_CLKDIV = 3'd3;
    localparam logic [2:0] REG_TXCMD  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SCK_LO = 3'd2,
        ST_SCK_HI = 3'd3,
        ST_HOLD   = 3'd4,
        ST_GAP    = 3'd5
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [DIV_WIDTH-1:0]    timer_r;
    logic [DIV_WIDTH-1:0]    div_sh_r;
    logic [FRAME_BITS-1:0]   tx_sh_r;
    logic [FRAME_BITS-1:0]   rx_r;
    logic [CNT_W-1:0]        bit_cnt_r;

    logic                    mem_ready_r;
    logic [31:0]             mem_rdata_r;
    logic                    spi_cs_r;
    logic                    spi_sck_r;
    logic                    spi_mosi_r;

    logic                    start_r;
    logic                    ctrl_cont_r;
    logic [DIV_WIDTH-1:0]    clkdiv_r;
    logic [FRAME_BITS-1:0]   txcmd_r;
    logic [FRAME_BITS-1:0]   data_r;
    logic                    done_r;
    logic                    overrun_r;

    logic                    sel_s;
    logic                    acc_s;
    logic                    wr_s;
    logic                    rd_s;
    logic [2:0]              reg_idx_s;
    logic                    data_rd_s;
    logic                    busy_s;
    logic [31:0]             rd_val_s;

    logic                    timer_done_s;
    logic                    state_chg_s;
    logic                    enter_setup_s;
    logic                    enter_hi_s;
    logic                    enter_lo_s;
    logic                    frame_end_s;
    logic                    cs_nxt_s;
    logic                    sck_nxt_s;
    logic                    mosi_nxt_s;

    logic                    unused_ok_s;

    assign mem_ready = mem_ready_r;
    assign mem_rdata = mem_rdata_r;
    assign spi_cs    = spi_cs_r;
    assign spi_sck   = spi_sck_r;
    assign spi_mosi  = spi_mosi_r;

    // The window is the 32-byte block containing BASE_ADDR; registers decode from bits [4:2].
    assign sel_s       = mem_valid && (mem_addr[31:5] == BASE_ADDR[31:5]);
    assign acc_s       = sel_s && !mem_ready_r;
    assign wr_s        = acc_s && (mem_wstrb != 4'b0000);
    assign rd_s        = acc_s && (mem_wstrb == 4'b0000);
    assign reg_idx_s   = mem_addr[4:2];
    assign data_rd_s   = rd_s && (reg_idx_s == REG_DATA);
    assign busy_s      = (state_r != ST_IDLE);
    assign unused_ok_s = &{1'b0, mem_addr[1:0], mem_wdata[31:FRAME_BITS]};

    assign timer_done_s = (timer_r == div_sh_r);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; every phase lasts D+1 cycles
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_r || ctrl_cont_r) begin
                    state_nxt_s = ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (timer_done_s) begin
                    state_nxt_s = ST_SCK_HI;
                end else begin
                    state_nxt_s = ST_SETUP;
                end
            end
            ST_SCK_HI: begin
                if (timer_done_s) begin
                    state_nxt_s = ST_SCK_LO;
                end else begin
                    state_nxt_s = ST_SCK_HI;
                end
            end
            ST_SCK_LO: begin
                if (timer_done_s && (bit_cnt_r == LAST_BIT)) begin
                    state_nxt_s = ST_HOLD;
                end else if (timer_done_s) begin
                    state_nxt_s = ST_SCK_HI;
                end else begin
                    state_nxt_s = ST_SCK_LO;
                end
            end
            ST_HOLD: begin
                if (timer_done_s) begin
                    state_nxt_s = ST_GAP;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_GAP: begin
                if (timer_done_s && ctrl_cont_r) begin
                    state_nxt_s = ST_SETUP;
                end else if (timer_done_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode: next values of the SPI pins and state-entry strobes
    always_comb begin
        state_chg_s   = (state_nxt_s != state_r);
        enter_setup_s = state_chg_s && (state_nxt_s == ST_SETUP);
        enter_hi_s    = state_chg_s && (state_nxt_s == ST_SCK_HI);
        enter_lo_s    = state_chg_s && (state_nxt_s == ST_SCK_LO);
        frame_end_s   = (state_r == ST_HOLD) && (state_nxt_s == ST_GAP);
        cs_nxt_s      = !(state_nxt_s inside {ST_SETUP, ST_SCK_LO, ST_SCK_HI, ST_HOLD});
        sck_nxt_s     = (state_nxt_s == ST_SCK_HI);
        if (cs_nxt_s) begin
            mosi_nxt_s = 1'b0;
        end else if (enter_setup_s) begin
            mosi_nxt_s = txcmd_r[FRAME_BITS-1];
        end else if (enter_lo_s) begin
            mosi_nxt_s = tx_sh_r[FRAME_BITS-2];
        end else begin
            mosi_nxt_s = spi_mosi_r;
        end
    end

    // Registered SPI pins
    always_ff @(posedge clk) begin
        if (reset) begin
            spi_cs_r   <= 1'b1;
            spi_sck_r  <= 1'b0;
            spi_mosi_r <= 1'b0;
        end else begin
            spi_cs_r   <= cs_nxt_s;
            spi_sck_r  <= sck_nxt_s;
            spi_mosi_r <= mosi_nxt_s;
        end
    end

    // Phase timer, shadow copies, bit counter and shift registers
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_r   <= {DIV_WIDTH{1'b0}};
            div_sh_r  <= {DIV_WIDTH{1'b0}};
            tx_sh_r   <= {FRAME_BITS{1'b0}};
            rx_r      <= {FRAME_BITS{1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (state_chg_s || (state_r == ST_IDLE)) begin
                timer_r <= {DIV_WIDTH{1'b0}};
            end else begin
                timer_r <= timer_r + DIV_WIDTH'(1);
            end
            if (enter_setup_s) begin
                div_sh_r  <= clkdiv_r;
                tx_sh_r   <= txcmd_r;
                bit_cnt_r <= {CNT_W{1'b0}};
            end else if (enter_lo_s) begin
                tx_sh_r   <= {tx_sh_r[FRAME_BITS-2:0], 1'b0};
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end else begin
                tx_sh_r   <= tx_sh_r;
                bit_cnt_r <= bit_cnt_r;
            end
            if (enter_hi_s) begin
                rx_r <= {rx_r[FRAME_BITS-2:0], spi_miso};
            end else begin
                rx_r <= rx_r;
            end
        end
    end

    // Read multiplexer; unmapped offsets and unused bits read as zero
    always_comb begin
        rd_val_s = 32'h0000_0000;
        case (reg_idx_s)
            REG_CTRL:   rd_val_s[1:0] = {ctrl_cont_r, 1'b0};
            REG_STATUS: rd_val_s[2:0] = {overrun_r, done_r, busy_s};
            REG_DATA:   rd_val_s[FRAME_BITS-1:0] = data_r;
            REG_CLKDIV: rd_val_s[DIV_WIDTH-1:0] = clkdiv_r;
            REG_TXCMD:  rd_val_s[FRAME_BITS-1:0] = txcmd_r;
            default:    rd_val_s = 32'h0000_0000;
        endcase
    end

    // Bus handshake and programmable registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_ready_r <= 1'b0;
            mem_rdata_r <= 32'h0000_0000;
            start_r     <= 1'b0;
            ctrl_cont_r <= 1'b0;
            clkdiv_r    <= DIV_WIDTH'(4);
            txcmd_r     <= {FRAME_BITS{1'b0}};
            data_r      <= {FRAME_BITS{1'b0}};
            done_r      <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            mem_ready_r <= acc_s;
            mem_rdata_r <= rd_s ? rd_val_s : 32'h0000_0000;
            // A START seen while a frame is running is dropped, not queued.
            start_r     <= wr_s && (reg_idx_s == REG_CTRL) && mem_wdata[0] && (state_r == ST_IDLE);
            if (wr_s && (reg_idx_s == REG_CTRL)) begin
                ctrl_cont_r <= mem_wdata[1];
            end else begin
                ctrl_cont_r <= ctrl_cont_r;
            end
            if (wr_s && (reg_idx_s == REG_CLKDIV)) begin
                clkdiv_r <= mem_wdata[DIV_WIDTH-1:0];
            end else begin
                clkdiv_r <= clkdiv_r;
            end
            if (wr_s && (reg_idx_s == REG_TXCMD)) begin
                txcmd_r <= mem_wdata[FRAME_BITS-1:0];
            end else begin
                txcmd_r <= txcmd_r;
            end
            if (frame_end_s) begin
                data_r <= rx_r;
                done_r <= 1'b1;
            end else if (data_rd_s) begin
                data_r <= data_r;
                done_r <= 1'b0;
            end else begin
                data_r <= data_r;
                done_r <= done_r;
            end
            // A result landing on the same edge as a DATA read does not count as lost.
            if (frame_end_s && done_r && !data_rd_s) begin
                overrun_r <= 1'b1;
            end else if (wr_s && (reg_idx_s == REG_STATUS) && mem_wdata[2]) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

endmodule
